pes_updown_counter: RTL and testbench

- Parametrised, modulo-programmable, multi-mode synchronous counter.
- Successor to the 2-bit ripple counter.
- Fully synchronous single-clock design with selectable up, down, bounce (ping-pong) and hold modes, parallel load, and a terminal-count pulse.
- Used as a generic timebase/sequence counter in pes_* designs.

---
 rtl/pes_cnt_pkg.sv | 18 +
 rtl/pes_cnt_prescaler.sv | 29 ++
 rtl/pes_updown_counter.sv | 119 +++++++++++
 tb/tb_pes_updown_counter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pes_cnt_pkg.sv
// Shared definitions for the pes_updown_counter family: mode encoding and the
// load clamp helper.
package pes_cnt_pkg;

    typedef enum logic [1:0] {
        CNT_UP     = 2'b00,
        CNT_DOWN   = 2'b01,
        CNT_BOUNCE = 2'b10,
        CNT_HOLD   = 2'b11
    } cnt_mode_e;

    // Saturate a load value at the largest legal count (MOD-1).
    function automatic logic [32:0] clamp_to_max(input logic [32:0] val,
                                                 input logic [32:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/pes_cnt_prescaler.sv
// Clock-enable divider: counts enabled cycles 0..PRESCALE-1 and raises tick on
// the enabled cycle that completes a period.
module pes_cnt_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/pes_updown_counter.sv
// Modulo-programmable up/down/bounce/hold counter with parallel load and a
// terminal-count pulse. Define PES_CNT_PRESCALE_EN to divide the step rate by PRESCALE.
module pes_updown_counter
    import pes_cnt_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MOD      = 64'd1 << WIDTH,
    parameter int              PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             dir_down,
    output logic             tc
);

    // One extra bit keeps MOD-1 and the increment representable when MOD == 2**WIDTH.
    localparam logic [WIDTH:0] ONE       = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] LAST      = (WIDTH+1)'(MOD - 1);
    localparam logic [32:0]    CLAMP_MAX = 33'(MOD - 1);

    cnt_mode_e       mode_e;
    logic            tick;
    logic            step;
    logic [WIDTH:0]  q_ext;
    logic [WIDTH:0]  q_inc;
    logic [WIDTH:0]  q_dec;
    logic [WIDTH-1:0] q_nxt;
    logic            dir_nxt;
    logic            tc_nxt;

`ifdef PES_CNT_PRESCALE_EN
    pes_cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );
`else
    // Without the prescaler every enabled edge is a step; PRESCALE has no effect.
    assign tick = (PRESCALE >= 1);
`endif

    assign mode_e = cnt_mode_e'(mode);
    assign step   = en && tick && (mode_e != CNT_HOLD);
    assign q_ext  = {1'b0, q};
    assign q_inc  = q_ext + ONE;
    assign q_dec  = q_ext - ONE;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        q_nxt   = q;
        dir_nxt = dir_down;
        tc_nxt  = 1'b0;
        if (load) begin
            q_nxt = WIDTH'(clamp_to_max(33'(load_val), CLAMP_MAX));
        end else if (step) begin
            case (mode_e)
                CNT_UP: begin
                    if (q_ext == LAST) begin
                        q_nxt  = '0;
                        tc_nxt = 1'b1;
                    end else begin
                        q_nxt = WIDTH'(q_inc);
                    end
                end
                CNT_DOWN: begin
                    if (q_ext == '0) begin
                        q_nxt  = WIDTH'(LAST);
                        tc_nxt = 1'b1;
                    end else begin
                        q_nxt = WIDTH'(q_dec);
                    end
                end
                CNT_BOUNCE: begin
                    if (!dir_down) begin
                        if (q_ext == LAST) begin
                            q_nxt   = WIDTH'(LAST - ONE);
                            dir_nxt = 1'b1;
                            tc_nxt  = 1'b1;
                        end else begin
                            q_nxt = WIDTH'(q_inc);
                        end
                    end else begin
                        if (q_ext == '0) begin
                            q_nxt   = WIDTH'(ONE);
                            dir_nxt = 1'b0;
                            tc_nxt  = 1'b1;
                        end else begin
                            q_nxt = WIDTH'(q_dec);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            q        <= '0;
            dir_down <= 1'b0;
            tc       <= 1'b0;
        end else begin
            q        <= q_nxt;
            dir_down <= dir_nxt;
            tc       <= tc_nxt;
        end
    end

endmodule

// File: tb/tb_pes_updown_counter.sv
// Self-checking bench for pes_updown_counter (WIDTH=4, MOD=10): directed vector
// table followed by random stimulus against a behavioural model.
module tb_pes_updown_counter;
    import pes_cnt_pkg::*;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;
`ifdef PES_CNT_PRESCALE_EN
    localparam int PRESC = 3;
`else
    localparam int PRESC = 1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] q;
    logic             dir_down;
    logic             tc;

    pes_updown_counter #(
        .WIDTH    (WIDTH),
        .MOD      (MOD),
        .PRESCALE (PRESC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .dir_down (dir_down),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one set of inputs, clock it in, and leave time for outputs to settle.
    task automatic apply(input logic r, input logic ld, input int lv, input logic e, input int m);
        @(negedge clk);
        reset    = r;
        load     = ld;
        load_val = WIDTH'(lv);
        en       = e;
        mode     = 2'(m);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       ld;
        int         lv;
        logic       en;
        int         mode;
        int         q;
        logic       dir;
        logic       tc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic ld, input int lv, input logic e,
                                input int m, input int eq, input logic ed, input logic et);
        vec_t v;
        v.rst = r; v.ld = ld; v.lv = lv; v.en = e; v.mode = m;
        v.q = eq; v.dir = ed; v.tc = et;
        vecs.push_back(v);
    endfunction

    // Behavioural reference: state and rules straight from the counter's description.
    int   mq, mpre;
    logic mdir, mtc;

    task automatic model_edge(input logic r, input logic ld, input int lv, input logic e, input int m);
        logic tk;
        if (r) begin
            mq = 0; mdir = 0; mtc = 0; mpre = 0;
        end else if (ld) begin
            mq = (lv > MOD - 1) ? MOD - 1 : lv;
            mtc = 0;
            mpre = 0;
        end else begin
            mtc = 0;
            tk = 0;
            if (e) begin
                tk = (mpre == PRESC - 1);
                mpre = tk ? 0 : mpre + 1;
            end
            if (tk && m != 3) begin
                case (m)
                    0: begin mtc = (mq == MOD - 1); mq = (mq + 1) % MOD; end
                    1: begin mtc = (mq == 0); mq = (mq + MOD - 1) % MOD; end
                    default: begin
                        if (!mdir) begin
                            if (mq == MOD - 1) begin mq = MOD - 2; mdir = 1; mtc = 1; end
                            else mq = mq + 1;
                        end else begin
                            if (mq == 0) begin mq = 1; mdir = 0; mtc = 1; end
                            else mq = mq - 1;
                        end
                    end
                endcase
            end
        end
    endtask

    initial begin
        // Directed table.
        add(1, 0, 0, 0, CNT_UP, 0, 0, 0);
        add(1, 0, 0, 0, CNT_UP, 0, 0, 0);
`ifndef PES_CNT_PRESCALE_EN
        for (int i = 1; i <= 9; i++) add(0, 0, 0, 1, CNT_UP, i, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 0, 0, 1);
        add(0, 0, 0, 1, CNT_UP, 1, 0, 0);
        add(0, 1, 0, 0, CNT_UP, 0, 0, 0);
        add(0, 0, 0, 1, CNT_DOWN, 9, 0, 1);
        add(0, 0, 0, 1, CNT_DOWN, 8, 0, 0);
        add(0, 0, 0, 1, CNT_DOWN, 7, 0, 0);
        add(0, 1, 0, 1, CNT_DOWN, 0, 0, 0);
        for (int i = 1; i <= 9; i++) add(0, 0, 0, 1, CNT_BOUNCE, i, 0, 0);
        add(0, 0, 0, 1, CNT_BOUNCE, 8, 1, 1);
        for (int i = 7; i >= 0; i--) add(0, 0, 0, 1, CNT_BOUNCE, i, 1, 0);
        add(0, 0, 0, 1, CNT_BOUNCE, 1, 0, 1);
        add(0, 0, 0, 1, CNT_BOUNCE, 2, 0, 0);
        add(0, 1, 9, 0, CNT_BOUNCE, 9, 0, 0);
        add(0, 0, 0, 1, CNT_BOUNCE, 8, 1, 1);
        add(0, 0, 0, 1, CNT_UP,     9, 1, 0);
        add(0, 0, 0, 1, CNT_BOUNCE, 8, 1, 0);
        add(0, 1, 13, 1, CNT_UP, 9, 1, 0);
        add(1, 1, 7, 1, CNT_UP, 0, 0, 0);
        add(0, 1, 9, 0, CNT_UP, 9, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 0, 0, 1);
        add(0, 1, 5, 0, CNT_UP, 5, 0, 0);
        add(0, 1, 9, 0, CNT_UP, 9, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 0, 0, 1);
        add(0, 0, 0, 1, CNT_HOLD, 0, 0, 0);
        add(0, 1, 3, 0, CNT_UP, 3, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 4, 0, 0);
        add(0, 0, 0, 0, CNT_UP, 4, 0, 0);
        add(0, 0, 0, 0, CNT_UP, 4, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 5, 0, 0);
        add(0, 0, 0, 1, CNT_HOLD, 5, 0, 0);
        add(0, 0, 0, 1, CNT_HOLD, 5, 0, 0);
`else
        add(0, 1, 0, 1, CNT_UP, 0, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 0, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 0, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 1, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 1, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 1, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 2, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 2, 0, 0);
        add(0, 1, 5, 1, CNT_UP, 5, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 5, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 5, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 6, 0, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].mode);
            check($sformatf("vec%0d q", i),        32'(q),        32'(vecs[i].q));
            check($sformatf("vec%0d dir_down", i), 32'(dir_down), 32'(vecs[i].dir));
            check($sformatf("vec%0d tc", i),       32'(tc),       32'(vecs[i].tc));
        end

        // Random stimulus against the model, starting from a reset.
        for (int i = 0; i < 2000; i++) begin
            logic r, ld, e;
            int   lv, m;
            r  = (i == 0) || ($urandom_range(0, 63) == 0);
            ld = ($urandom_range(0, 7) == 0);
            lv = int'($urandom_range(0, 15));
            e  = ($urandom_range(0, 3) != 0);
            m  = int'($urandom_range(0, 3));
            apply(r, ld, lv, e, m);
            model_edge(r, ld, lv, e, m);
            check($sformatf("rnd%0d q", i),        32'(q),        32'(mq));
            check($sformatf("rnd%0d dir_down", i), 32'(dir_down), 32'(mdir));
            check($sformatf("rnd%0d tc", i),       32'(tc),       32'(mtc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
